// File: rtl/fir_pe_pkg.sv
// fir_pe_pkg: run-controller state encoding and default widths, shared by the
// controller RTL and the emulation wrapper.
package fir_pe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        WAIT  = 2'd3
    } fir_state_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    localparam int FIR_TAPS_DEF = 8;
    localparam int FIR_CW_DEF   = 8;
    localparam int FIR_XW_DEF   = 4;

    function automatic logic addr_in_range(input logic [31:0] addr, input int n);
        return (addr < $unsigned(n));
    endfunction

endpackage

// File: rtl/fir_pe_coef_rf.sv
// fir_pe_coef_rf: N_TAPS x CW coefficient register file with a single write
// port and a flattened read bus (slice k feeds PE k).
module fir_pe_coef_rf
    import fir_pe_pkg::*;
#(
    parameter int N_TAPS = FIR_TAPS_DEF,
    parameter int CW     = FIR_CW_DEF,
    parameter int AW     = $clog2(N_TAPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [CW-1:0]        wdata,
    output logic [N_TAPS*CW-1:0] rd_bus
);
    logic [CW-1:0] coef_r [N_TAPS];
    logic          wr_ok_s;

    assign wr_ok_s = we & addr_in_range(32'(addr), N_TAPS);

    // Coefficient storage; addresses past the last tap never match a row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_TAPS; k++) begin
                coef_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_TAPS; k++) begin
                if (wr_ok_s && (addr == AW'(k))) begin
                    coef_r[k] <= wdata;
                end
            end
        end
    end

    for (genvar g = 0; g < N_TAPS; g++) begin : g_rd
        assign rd_bus[g*CW +: CW] = coef_r[g];
    end

endmodule

// File: rtl/fir_pe_ctrl.sv
// fir_pe_ctrl: run controller for a systolic fir_pe chain -- holds coefficients,
// streams samples with flush, and forwards exactly run_len results.
module fir_pe_ctrl
    import fir_pe_pkg::*;
#(
    parameter int N_TAPS = 8,
    parameter int CW     = 8,
    parameter int XW     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    input  logic [$clog2(N_TAPS)-1:0] cfg_addr,
    input  logic [CW-1:0]             cfg_data,
    input  logic                      start,
    input  logic [7:0]                run_len,
    input  logic                      abort,
    input  logic [XW-1:0]             in_x,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [N_TAPS*CW-1:0]      pe_cin,
    output logic [XW-1:0]             pe_xin,
    output logic [XW-1:0]             pe_yin,
    output logic                      pe_rdy,
    input  logic [XW-1:0]             pe_yout,
    input  logic                      pe_vld,
    output logic [XW-1:0]             y_out,
    output logic                      y_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err
);
    localparam int AW = $clog2(N_TAPS);

    logic [1:0]    state_r, state_nxt_s;
    logic [7:0]    rem_in_r, rem_in_nxt_s, rem_out_r;
    logic [AW-1:0] flush_cnt_r, flush_nxt_s;
    logic [8:0]    in_flight_r, in_flight_nxt_s;
    logic          push_s, start_ok_s, abort_hit_s, done_nxt_s, coef_we_s;
    logic [XW-1:0] push_x_s;
    logic          aborted_r, in_ready_r, pe_rdy_r, y_valid_r, busy_r, done_r, cfg_err_r;
    logic [XW-1:0] pe_xin_r, y_out_r;

    assign coef_we_s = cfg_we & (state_r == ST_IDLE);

    fir_pe_coef_rf #(.N_TAPS(N_TAPS), .CW(CW), .AW(AW)) u_coef_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (coef_we_s),
        .addr   (cfg_addr),
        .wdata  (cfg_data),
        .rd_bus (pe_cin)
    );

    // Run sequencing: next state, sample/flush pushes and run completion
    always_comb begin
        state_nxt_s  = state_r;
        rem_in_nxt_s = rem_in_r;
        flush_nxt_s  = flush_cnt_r;
        push_s       = 1'b0;
        push_x_s     = pe_xin_r;
        start_ok_s   = 1'b0;
        abort_hit_s  = 1'b0;
        done_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && (run_len != 8'd0)) begin
                    start_ok_s   = 1'b1;
                    rem_in_nxt_s = run_len;
                    state_nxt_s  = ST_RUN;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    abort_hit_s = 1'b1;
                    state_nxt_s = ST_WAIT;
                end else if (in_valid && in_ready_r) begin
                    push_s       = 1'b1;
                    push_x_s     = in_x;
                    rem_in_nxt_s = rem_in_r - 8'd1;
                    if (rem_in_r == 8'd1) begin
                        flush_nxt_s = AW'(N_TAPS - 1);
                        state_nxt_s = ST_FLUSH;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    abort_hit_s = 1'b1;
                    state_nxt_s = ST_WAIT;
                end else if (flush_cnt_r != {AW{1'b0}}) begin
                    push_s      = 1'b1;
                    push_x_s    = {XW{1'b0}};
                    flush_nxt_s = flush_cnt_r - AW'(1);
                    state_nxt_s = (flush_cnt_r == AW'(1)) ? ST_WAIT : ST_FLUSH;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A push issued this cycle is not yet in in_flight_r, so hold for it too
                if ((rem_out_r == 8'd0) && (in_flight_r == 9'd0) && !pe_rdy_r) begin
                    done_nxt_s  = ~aborted_r;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Results still inside the chain; a stray pe_vld at zero cannot wrap
    always_comb begin
        case ({pe_rdy_r, pe_vld})
            2'b10:   in_flight_nxt_s = in_flight_r + 9'd1;
            2'b01:   in_flight_nxt_s = (in_flight_r != 9'd0) ? (in_flight_r - 9'd1) : in_flight_r;
            default: in_flight_nxt_s = in_flight_r;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rem_in_r    <= 8'd0;
            rem_out_r   <= 8'd0;
            flush_cnt_r <= {AW{1'b0}};
            in_flight_r <= 9'd0;
            aborted_r   <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            pe_rdy_r    <= 1'b0;
            pe_xin_r    <= {XW{1'b0}};
            done_r      <= 1'b0;
            y_out_r     <= {XW{1'b0}};
            y_valid_r   <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            rem_in_r    <= rem_in_nxt_s;
            flush_cnt_r <= flush_nxt_s;
            in_flight_r <= in_flight_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_RUN);
            busy_r      <= (state_nxt_s != ST_IDLE);
            pe_rdy_r    <= push_s;
            pe_xin_r    <= push_x_s;
            done_r      <= done_nxt_s;
            y_out_r     <= pe_yout;
            y_valid_r   <= pe_vld & (rem_out_r != 8'd0) & ~abort_hit_s;
            if (start_ok_s) begin
                rem_out_r <= run_len;
            end else if (abort_hit_s) begin
                rem_out_r <= 8'd0;
            end else if (pe_vld && (rem_out_r != 8'd0)) begin
                rem_out_r <= rem_out_r - 8'd1;
            end
            if (start_ok_s) begin
                aborted_r <= 1'b0;
            end else if (abort_hit_s) begin
                aborted_r <= 1'b1;
            end
            if (start_ok_s) begin
                cfg_err_r <= 1'b0;
            end else if (cfg_we && (state_r != ST_IDLE)) begin
                cfg_err_r <= 1'b1;
            end
        end
    end

    assign in_ready = in_ready_r;
    assign busy     = busy_r;
    assign pe_rdy   = pe_rdy_r;
    assign pe_xin   = pe_xin_r;
    assign pe_yin   = {XW{1'b0}};
    assign done     = done_r;
    assign y_out    = y_out_r;
    assign y_valid  = y_valid_r;
    assign cfg_err  = cfg_err_r;

endmodule

// File: tb/tb_fir_pe_ctrl.sv
// tb_fir_pe_ctrl: self-checking bench for fir_pe_ctrl; a behavioural PE chain
// answers pushes, and results are checked against a direct convolution model.
module tb_fir_pe_ctrl;
    localparam int N = 8, CW = 8, XW = 4, LAT = 3, N10 = 10;

    logic clk_dut = 1'b0;
    always #5 clk_dut = ~clk_dut;

    logic rst_n, cfg_we, start, abort, in_valid, in_ready, pe_rdy, pe_vld;
    logic y_valid, busy, done, cfg_err;
    logic [2:0] cfg_addr;
    logic [CW-1:0] cfg_data;
    logic [7:0] run_len;
    logic [XW-1:0] in_x, pe_xin, pe_yin, pe_yout, y_out;
    logic [N*CW-1:0] pe_cin;

    logic cfg10_we, in_ready10, pe_rdy10, y_valid10, busy10, done10, cfg_err10;
    logic [3:0] cfg10_addr;
    logic [CW-1:0] cfg10_data;
    logic [XW-1:0] pe_xin10, pe_yin10, y_out10;
    logic [N10*CW-1:0] pe_cin10;

    fir_pe_ctrl #(.N_TAPS(N), .CW(CW), .XW(XW)) dut (
        .clk(clk_dut), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .run_len(run_len), .abort(abort), .in_x(in_x), .in_valid(in_valid),
        .in_ready(in_ready), .pe_cin(pe_cin), .pe_xin(pe_xin), .pe_yin(pe_yin), .pe_rdy(pe_rdy),
        .pe_yout(pe_yout), .pe_vld(pe_vld), .y_out(y_out), .y_valid(y_valid), .busy(busy),
        .done(done), .cfg_err(cfg_err)
    );

    fir_pe_ctrl #(.N_TAPS(N10), .CW(CW), .XW(XW)) dut10 (
        .clk(clk_dut), .rst_n(rst_n), .cfg_we(cfg10_we), .cfg_addr(cfg10_addr), .cfg_data(cfg10_data),
        .start(1'b0), .run_len(8'd0), .abort(1'b0), .in_x(4'd0), .in_valid(1'b0),
        .in_ready(in_ready10), .pe_cin(pe_cin10), .pe_xin(pe_xin10), .pe_yin(pe_yin10), .pe_rdy(pe_rdy10),
        .pe_yout(4'd0), .pe_vld(1'b0), .y_out(y_out10), .y_valid(y_valid10), .busy(busy10),
        .done(done10), .cfg_err(cfg_err10)
    );

    // Behavioural stand-in for the PE chain: one result per push, LAT cycles later
    logic [XW-1:0] hist [N-1];
    logic [LAT-1:0] vpipe;
    logic [XW-1:0] ypipe [LAT];
    logic [XW-1:0] chain_y;
    int chain_acc;

    always_comb begin
        chain_acc = int'(pe_cin[CW-1:0]) * int'(pe_xin);
        for (int k = 1; k < N; k++) chain_acc = chain_acc + int'(pe_cin[k*CW +: CW]) * int'(hist[k-1]);
        chain_y = XW'(chain_acc);
    end

    always_ff @(posedge clk_dut or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
            for (int k = 0; k < LAT; k++) ypipe[k] <= '0;
            for (int k = 0; k < N - 1; k++) hist[k] <= '0;
        end else begin
            vpipe <= {vpipe[LAT-2:0], pe_rdy};
            ypipe[0] <= chain_y;
            for (int k = 1; k < LAT; k++) ypipe[k] <= ypipe[k-1];
            if (pe_rdy) begin
                hist[0] <= pe_xin;
                for (int k = 1; k < N - 1; k++) hist[k] <= hist[k-1];
            end
        end
    end
    assign pe_vld  = vpipe[LAT-1];
    assign pe_yout = ypipe[LAT-1];

    // Output monitor, sampled on the falling edge
    logic [XW-1:0] yq[$], pushq[$];
    int done_cnt = 0;
    always @(negedge clk_dut) begin
        if (y_valid) yq.push_back(y_out);
        if (pe_rdy) pushq.push_back(pe_xin);
        if (done) done_cnt <= done_cnt + 1;
    end

    int n_chk = 0, n_fail = 0;
    int coef_m [N];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: y[n] = sum_k c[k]*x[n-k] mod 2^XW, zero history before the run
    function automatic logic [XW-1:0] ref_y(input logic [XW-1:0] xs[$], input int n);
        int acc = 0;
        for (int k = 0; k < N; k++) if (n - k >= 0) acc += coef_m[k] * int'(xs[n-k]);
        return XW'(acc % (1 << XW));
    endfunction

    task automatic cfg_write(input logic [2:0] a, input logic [CW-1:0] d);
        @(negedge clk_dut);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk_dut);
        cfg_we = 1'b0;
        coef_m[a] = int'(d);
    endtask

    // One complete run; stall: 0 none, 1 alternate, 2 random
    task automatic do_run(input int len, input int stall, input logic [XW-1:0] xs[$], input bit cfg_mid);
        int y0, p0, d0, idx, cyc;
        bit hs, ok, got;
        y0 = yq.size(); p0 = pushq.size(); d0 = done_cnt;
        @(negedge clk_dut);
        start = 1'b1; run_len = 8'(len);
        @(negedge clk_dut);
        start = 1'b0;
        check("start_busy_ready_err", {busy, in_ready, cfg_err}, 3'b110);
        idx = 0; cyc = 0;
        while (idx < len && cyc < 400) begin
            in_valid = (stall == 0) ? 1'b1 : (stall == 1) ? 1'((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            in_x = xs[idx];
            cfg_we = cfg_mid && (cyc == 0); cfg_addr = 3'd0; cfg_data = 8'hAA;
            hs = in_valid && in_ready;
            if (hs) idx++;
            @(negedge clk_dut);
            cyc++;
            cfg_we = 1'b0;
            if (hs && idx == 1) check("hs_push", {pe_rdy, pe_xin}, {1'b1, xs[0]});
        end
        check("feed_budget", 1'(idx == len), 1'b1);
        in_valid = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (!pe_rdy) ok = 1'b0;
            @(negedge clk_dut);
        end
        check("flush_train", {ok, pe_rdy}, 2'b10);
        cyc = 0; got = 1'b0;
        while (!got && cyc < 300) begin
            if (done) got = 1'b1;
            else begin @(negedge clk_dut); cyc++; end
        end
        check("done_seen", got, 1'b1);
        check("busy_with_done", busy, 1'b0);
        @(negedge clk_dut);
        check("done_pulse", {done, busy}, 2'b00);
        check("done_count", done_cnt - d0, 1);
        check("y_count", yq.size() - y0, len);
        for (int n = 0; n < len && (y0 + n) < yq.size(); n++)
            check($sformatf("y_%0d", n), yq[y0 + n], ref_y(xs, n));
        check("push_count", pushq.size() - p0, len + N - 1);
        ok = 1'b1;
        for (int i = 0; i < len + N - 1 && (p0 + i) < pushq.size(); i++)
            if (pushq[p0 + i] !== ((i < len) ? xs[i] : 4'd0)) ok = 1'b0;
        check("push_data", ok, 1'b1);
    endtask

    typedef struct {
        bit          sel10;
        logic [3:0]  addr;
        logic [7:0]  data;
        int          chk;
        logic [7:0]  exp;
    } cvec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cvec_t cv [12];
        logic [XW-1:0] xq[$];
        logic [7:0] slice;
        logic [N10*CW-1:0] e10;
        int y0, d0, p0, cyc;
        bit ok;

        for (int k = 0; k < N; k++) cv[k] = '{1'b0, 4'(k), 8'(k + 1), k, 8'(k + 1)};
        cv[8]  = '{1'b1, 4'd9,  8'h5A, 9, 8'h5A};
        cv[9]  = '{1'b1, 4'd12, 8'h33, 9, 8'h5A};
        cv[10] = '{1'b1, 4'd3,  8'h11, 3, 8'h11};
        cv[11] = '{1'b1, 4'd15, 8'hFF, 3, 8'h11};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 8'd0; start = 1'b0;
        run_len = 8'd0; abort = 1'b0; in_x = 4'd0; in_valid = 1'b0;
        cfg10_we = 1'b0; cfg10_addr = 4'd0; cfg10_data = 8'd0;
        for (int k = 0; k < N; k++) coef_m[k] = 0;
        repeat (3) @(negedge clk_dut);
        rst_n = 1'b1;
        @(negedge clk_dut);
        check("reset_outputs", {in_ready, pe_rdy, y_valid, busy, done, cfg_err, pe_xin, y_out, pe_yin}, 18'd0);
        check("reset_coef", pe_cin, 64'd0);
        check("reset_outputs10", {in_ready10, pe_rdy10, y_valid10, busy10, done10, cfg_err10,
                                  pe_xin10, y_out10, pe_yin10, pe_cin10}, 98'd0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk_dut);
            if (cv[i].sel10) begin
                cfg10_we = 1'b1; cfg10_addr = cv[i].addr; cfg10_data = cv[i].data;
            end else begin
                cfg_we = 1'b1; cfg_addr = cv[i].addr[2:0]; cfg_data = cv[i].data;
                coef_m[cv[i].addr[2:0]] = int'(cv[i].data);
            end
            @(negedge clk_dut);
            cfg_we = 1'b0; cfg10_we = 1'b0;
            slice = cv[i].sel10 ? pe_cin10[cv[i].chk*CW +: CW] : pe_cin[cv[i].chk*CW +: CW];
            check($sformatf("coef_vec_%0d", i), slice, cv[i].exp);
        end
        e10 = '0; e10[9*CW +: CW] = 8'h5A; e10[3*CW +: CW] = 8'h11;
        check("coef_bus10", pe_cin10, e10);

        // Impulse: results are the coefficients themselves
        xq = {4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        y0 = yq.size();
        do_run(8, 0, xq, 1'b0);
        check("impulse_last", yq[yq.size() - 1], 4'd8);

        // Same short run unstalled and with alternating stalls
        xq = {};
        for (int i = 0; i < 4; i++) xq.push_back(4'($urandom_range(0, 15)));
        do_run(4, 0, xq, 1'b0);
        do_run(4, 1, xq, 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N; k++) cfg_write(3'(k), 8'($urandom_range(0, 255)));
            xq = {};
            for (int i = 0; i < 12; i++) xq.push_back(4'($urandom_range(0, 15)));
            do_run($urandom_range(1, 12), r, xq, 1'b0);
        end

        // Coefficient write attempted mid-run
        do_run(3, 0, xq, 1'b1);
        check("cfg_mid_err", cfg_err, 1'b1);
        check("cfg_mid_coef0", pe_cin[CW-1:0], 8'(coef_m[0]));
        do_run(2, 2, xq, 1'b0);

        // Zero-length start is ignored
        @(negedge clk_dut);
        start = 1'b1; run_len = 8'd0;
        @(negedge clk_dut);
        start = 1'b0;
        check("zero_len_idle", {busy, in_ready}, 2'b00);
        repeat (3) @(negedge clk_dut);
        check("zero_len_quiet", {busy, pe_rdy}, 2'b00);

        // Abort after two of five samples
        y0 = yq.size(); d0 = done_cnt; p0 = pushq.size();
        @(negedge clk_dut);
        start = 1'b1; run_len = 8'd5;
        @(negedge clk_dut);
        start = 1'b0; in_valid = 1'b1; in_x = 4'd7;
        @(negedge clk_dut);
        in_x = 4'd3;
        @(negedge clk_dut);
        in_valid = 1'b0; abort = 1'b1;
        @(negedge clk_dut);
        abort = 1'b0;
        ok = 1'b1; cyc = 0;
        while (busy && cyc < 50) begin
            if (in_ready) ok = 1'b0;
            @(negedge clk_dut);
            cyc++;
        end
        check("abort_no_ready", ok, 1'b1);
        check("abort_busy_drop", busy, 1'b0);
        check("abort_no_y", yq.size() - y0, 0);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_pushes", pushq.size() - p0, 2);

        // Reset in the middle of the flush
        @(negedge clk_dut);
        start = 1'b1; run_len = 8'd3;
        @(negedge clk_dut);
        start = 1'b0; in_valid = 1'b1;
        repeat (3) @(negedge clk_dut);
        in_valid = 1'b0;
        @(negedge clk_dut);
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 8'h77;
        @(negedge clk_dut);
        cfg_we = 1'b0;
        check("flush_state", {busy, pe_rdy, cfg_err}, 3'b111);
        rst_n = 1'b0;
        #1;
        check("rst_mid_flush", {in_ready, pe_rdy, y_valid, busy, done, cfg_err, pe_xin, y_out, pe_yin}, 18'd0);
        check("rst_mid_flush_coef", pe_cin, 64'd0);
        @(negedge clk_dut);
        rst_n = 1'b1;
        @(negedge clk_dut);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_pe_ctrl.md
# fir_pe_ctrl

Run controller for a systolic chain of `N_TAPS` `fir_pe` processing elements. It holds the coefficient register file and drives each PE's `Cin`. It streams input samples into the head of the chain with a valid/ready handshake, pushes zero samples to flush the pipeline, and forwards exactly `run_len` results from the chain tail. It sits between the co-emulation transactor (or host logic) and the PE chain, replacing direct per-PE stimulus.

## Interface
Parameters:
- `N_TAPS`, 8, number of chained PEs and coefficients (2..16)
- `CW`, 8, coefficient width (matches PE `Cin`)
- `XW`, 4, sample and accumulator width (matches PE `Xin`/`Yout`)

Ports:
- `clk` in 1: single clock; all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `cfg_we` in 1: coefficient write strobe
- `cfg_addr` in $clog2(N_TAPS): coefficient index
- `cfg_data` in CW: coefficient value
- `start` in 1: begin run; sampled only in IDLE
- `run_len` in 8: number of samples in the run; sampled with `start`
- `abort` in 1: terminate current run
- `in_x` in XW: input sample
- `in_valid` in 1: sample present
- `in_ready` out 1: controller accepts sample
- `pe_cin` out N_TAPS*CW: coefficient bus; slice k drives PE k
- `pe_xin` out XW: sample into PE 0
- `pe_yin` out XW: constant 0 into PE 0 `Yin`
- `pe_rdy` out 1: push strobe into PE 0
- `pe_yout` in XW: result from last PE
- `pe_vld` in 1: result valid from last PE
- `y_out` out XW: forwarded result
- `y_valid` out 1: result strobe
- `busy` out 1: state != IDLE
- `done` out 1: one-cycle pulse when a run completes normally
- `cfg_err` out 1: sticky; set when `cfg_we` is seen outside IDLE; cleared by `start`

## Operation
States:
- **IDLE**
  - `cfg_we` writes `coef[cfg_addr]`. Addresses ≥ N_TAPS are ignored.
  - `start` with `run_len` != 0 latches `run_len` into `rem_in` and `rem_out`, clears `cfg_err`, and moves to RUN.
  - `start` with `run_len` == 0 is ignored.
- **RUN**
  - `in_ready` = 1.
  - On a handshake (`in_valid & in_ready`): register `pe_xin` = `in_x`, pulse `pe_rdy` for one cycle, decrement `rem_in`.
  - When `rem_in` reaches 0, set `flush_cnt` = N_TAPS-1 and move to FLUSH.
- **FLUSH**
  - `in_ready` = 0.
  - Push `pe_xin` = 0 with `pe_rdy` = 1 on each cycle until `flush_cnt` = 0, then move to WAIT.
- **WAIT**
  - Stay until `rem_out` = 0 and `in_flight` = 0.
  - Then pulse `done` and return to IDLE.

Counters and gating:
- `in_flight` (9 bits): +1 on each `pe_rdy` push, -1 on each `pe_vld`, net change on simultaneous events.
- `y_valid` = registered (`pe_vld` & `rem_out` != 0). `y_out` = registered `pe_yout`. `rem_out` decrements on each forwarded result.
- Flush results beyond `run_len` are discarded.
- `abort` in RUN or FLUSH:
  - Stop pushing and go to WAIT with `rem_out` forced to 0, so no further `y_valid`.
  - `done` is not pulsed.
  - `abort` in IDLE or WAIT has no effect.
- `cfg_we` outside IDLE: the write is dropped and `cfg_err` is set.
- `pe_cin` is driven combinationally from `coef`, so coefficients are stable throughout a run.
- `pe_xin` holds its last value when not pushing.

## Timing
- Reset values:
  - `in_ready`, `pe_rdy`, `y_valid`, `busy`, `done`, `cfg_err` = 0.
  - `pe_xin`, `y_out` = 0.
  - all `coef` = 0, all counters = 0, state = IDLE.
- `start` in cycle t: `busy` and `in_ready` = 1 in cycle t+1.
- Handshake in cycle t: `pe_rdy` and `pe_xin` valid in cycle t+1.
- The last sample handshake at t is followed by N_TAPS-1 consecutive flush pushes starting at t+2.
- Result path latency: `pe_vld` in cycle t gives `y_valid` in cycle t+1.
- `done` asserts the cycle after WAIT observes both counters at zero. `busy` drops in that same cycle.
- Maximum throughput is one sample per cycle. `in_valid` may stall arbitrarily with no loss.
- Asserting `rst_n` mid-run clears everything immediately. Outputs still in flight in the chain are not tracked after reset.

## Structure
- Package `fir_pe_pkg`: state enum (IDLE, RUN, FLUSH, WAIT) and default CW/XW constants, shared with the emulation wrapper.
- Sub-module `fir_pe_coef_rf`: N_TAPS×CW register file with write port and flattened read bus.
- A top-level test harness instantiates `fir_pe_ctrl` plus an N_TAPS `fir_pe` chain.

## Test plan
- **Coefficient load:** write `coef[0..7]` = 1..8 in IDLE -> `pe_cin` slice k = k+1. Write to addr 9 with N_TAPS=10 goes to the correct slice; an out-of-range address is ignored.
- **Impulse:** coefficients 1..8, `run_len` = 8, `in_x` = {1,0,0,0,0,0,0,0} back-to-back -> exactly 8 `y_valid` with the chain's impulse response (mod 16), then one `done`, and `busy` returns to 0.
- **Stalls:** `run_len` = 4, `in_valid` toggled 1/0 -> exactly 4 pushes, 7 flush pushes, 4 `y_valid`, results identical to the unstalled run.
- **Abort:** `abort` after 2 of 5 samples -> no further `in_ready` or `y_valid`, no `done`, `busy` drops once `in_flight` = 0.
- **Config during run:** `cfg_we` in RUN -> `coef` unchanged, `cfg_err` = 1, then cleared by the next `start`.
- **Reset and zero length:** `rst_n` low mid-FLUSH -> all outputs at reset values next cycle. `start` with `run_len` = 0 -> stays IDLE.
